// File: rtl/pll_mgr_pkg.sv
// rtl/pll_mgr_pkg.sv - shared types and width helpers for the PLL lock manager
`timescale 1ns/1ps
package pll_mgr_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    RESTART,
    FAIL
  } pll_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchroniser for a single asynchronous bit
`timescale 1ns/1ps
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through STAGES flops, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_lock_mgr.sv
// rtl/pll_lock_mgr.sv - PLL lock supervisor with staggered reset release and retry
`timescale 1ns/1ps
module pll_lock_mgr
  import pll_mgr_pkg::*;
#(
  parameter int NUM_RST      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILT    = 64,
  parameter int STAGGER      = 4,
  parameter int LOCK_TIMEOUT = 10000,
  parameter int PULSE_LEN    = 8,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               stdy_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fail,
  output logic [CNT_W-1:0]   loss_count
);

  // One counter serves as timeout timer, filter counter, release counter and
  // pulse counter; only one of those is live in any given state.
  localparam int CNT_MAX = max2(max2(LOCK_TIMEOUT - 1, LOCK_FILT - 1),
                                max2((NUM_RST - 1) * STAGGER, PULSE_LEN - 1));
  localparam int CW = cnt_width(CNT_MAX);
  localparam int RW = cnt_width(MAX_RETRY);

  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILT_END    = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] REL_END     = CW'((NUM_RST - 1) * STAGGER);
  localparam logic [CW-1:0] PULSE_END   = CW'(PULSE_LEN - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic               lk;
  pll_state_t         state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [RW-1:0]      retry, retry_nxt;
  logic [NUM_RST-1:0] rst_q, rst_nxt;
  logic               ready_q, ready_nxt;
  logic               fail_q, fail_nxt;
  logic               stdy_q, stdy_nxt;
  logic [CNT_W-1:0]   loss_q, loss_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (pll_locked),
    .q   (lk)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    rst_nxt   = rst_q;
    ready_nxt = ready_q;
    fail_nxt  = fail_q;
    stdy_nxt  = stdy_q;
    loss_nxt  = loss_q;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = cnt + 1'b1;
        if (lk) begin
          state_nxt = FILTER;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_END) begin
          state_nxt = RESTART;
          cnt_nxt   = '0;
          stdy_nxt  = 1'b1;
          retry_nxt = retry + 1'b1;
        end
      end
      FILTER: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == FILT_END) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!lk) begin
          // Lock lost before all domains came out of reset: start over quietly.
          rst_nxt   = '1;
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
          for (int i = 0; i < NUM_RST; i++) begin
            if (cnt == CW'(i * STAGGER)) rst_nxt[i] = 1'b0;
          end
          if (cnt == REL_END) begin
            ready_nxt = 1'b1;
            retry_nxt = '0;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!lk) begin
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          if (loss_q != {CNT_W{1'b1}}) loss_nxt = loss_q + 1'b1;
          state_nxt = RESTART;
          cnt_nxt   = '0;
          stdy_nxt  = 1'b1;
          retry_nxt = retry + 1'b1;
        end
      end
      RESTART: begin
        // lk is deliberately ignored until the restart pulse completes.
        if (cnt == PULSE_END) begin
          stdy_nxt = 1'b0;
          cnt_nxt  = '0;
          if (MAX_RETRY != 0 && retry == RETRY_LIMIT) begin
            state_nxt = FAIL;
            fail_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_LOCK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FAIL: begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        stdy_nxt  = 1'b0;
        fail_nxt  = 1'b1;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered outputs, all cleared by async reset.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      retry   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
      stdy_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      retry   <= retry_nxt;
      rst_q   <= rst_nxt;
      ready_q <= ready_nxt;
      fail_q  <= fail_nxt;
      stdy_q  <= stdy_nxt;
      loss_q  <= loss_nxt;
    end
  end

  assign rst_out    = rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign stdy_rst   = stdy_q;
  assign loss_count = loss_q;

endmodule
